// File: rtl/dmem_access_ctrl_if.sv
// CPU <-> data-memory handshake bundle used by dmem_access_ctrl.
// master: the access controller; slave: the CPU/memory environment.
interface dmem_access_ctrl_if #(
  parameter int unsigned N = 8
);
  logic         cpu_read;
  logic         cpu_write;
  logic [N-1:0] cpu_address;
  logic [N-1:0] cpu_writedata;
  logic [N-1:0] cpu_readdata;
  logic         cpu_stall;
  logic         cpu_error;
  logic         mem_read;
  logic         mem_write;
  logic [N-1:0] mem_address;
  logic [N-1:0] mem_writedata;
  logic [N-1:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    input  cpu_read, cpu_write, cpu_address, cpu_writedata, mem_readdata, mem_busywait,
    output cpu_readdata, cpu_stall, cpu_error, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    output cpu_read, cpu_write, cpu_address, cpu_writedata, mem_readdata, mem_busywait,
    input  cpu_readdata, cpu_stall, cpu_error, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns CPU load/store requests into held mem_read/mem_write
// requests with busywait handshake and timeout abort. Optional macro: POSTED_WRITE_EN.
module dmem_access_ctrl #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset,
  dmem_access_ctrl_if.master bus
);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q, state_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic [TW-1:0] count_q, count_d;

  logic          stall;
  logic          error;
  logic [N-1:0]  readdata;
  logic          cpu_req;
  logic          cpu_illegal;
  logic          count_last;
  logic          posted_busy;
  logic          accept_stall;

  assign cpu_req     = bus.cpu_read | bus.cpu_write;
  assign cpu_illegal = bus.cpu_read & bus.cpu_write;
  assign count_last  = (count_q == TW'(TIMEOUT - 1));

`ifdef POSTED_WRITE_EN
  // An in-flight store only stalls the CPU if it presents another request.
  assign posted_busy  = mem_write_q;
  assign accept_stall = ~bus.cpu_write;
`else
  assign posted_busy  = 1'b0;
  assign accept_stall = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    count_d     = count_q;
    stall       = 1'b0;
    error       = 1'b0;
    readdata    = rdata_q;

    case (state_q)
      StIdle: begin
        if (cpu_illegal) begin
          error = 1'b1;
        end else if (cpu_req) begin
          state_d     = StIssue;
          mem_read_d  = bus.cpu_read;
          mem_write_d = bus.cpu_write;
          addr_d      = bus.cpu_address;
          wdata_d     = bus.cpu_writedata;
          count_d     = '0;
          stall       = accept_stall;
        end
      end
      StIssue: begin
        // Memory may raise busywait combinationally with the request, so it is ignored here.
        state_d = StWait;
        count_d = count_q + TW'(1);
        stall   = posted_busy ? cpu_req : 1'b1;
      end
      StWait: begin
        count_d = count_q + TW'(1);
        if (!bus.mem_busywait) begin
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          stall       = posted_busy ? cpu_req : 1'b0;
          if (mem_read_q) begin
            readdata = bus.mem_readdata;
            rdata_d  = bus.mem_readdata;
          end
        end else if (count_last) begin
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          error       = 1'b1;
          stall       = posted_busy ? cpu_req : 1'b0;
          if (mem_read_q) begin
            readdata = '0;
            rdata_d  = '0;
          end
        end else begin
          stall = posted_busy ? cpu_req : 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      count_q     <= count_d;
    end
  end

  // Stall and error are combinational and must stay quiet while reset is held.
  assign bus.cpu_stall     = stall & ~reset;
  assign bus.cpu_error     = error & ~reset;
  assign bus.cpu_readdata  = readdata;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wdata_q;

  a_req_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(mem_read_q && mem_write_q));
  a_idle_no_req: assert property (@(posedge clk) disable iff (reset)
    (state_q == StIdle) |-> !(mem_read_q || mem_write_q));
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, corner sequences and
// randomized accesses against a transaction-level reference model.
module tb_dmem_access_ctrl;
  localparam int TMO = 8;
`ifdef POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.N(8)) bus ();
  dmem_access_ctrl #(.N(8), .TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int mem_b   = 0;
  int req_age = 0;
  int overlap = 0;
  logic [7:0] env_mem   [256];
  logic [7:0] model_mem [256];
  logic [7:0] model_rdata;

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h10) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  // Memory environment: busywait high for mem_b cycles after a request rises.
  always_ff @(posedge clk) req_age <= (bus.mem_read | bus.mem_write) ? req_age + 1 : 0;
  assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (req_age < mem_b);
  assign bus.mem_readdata = env_mem[bus.mem_address];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
    end else if (bus.mem_write && !bus.mem_busywait) begin
      env_mem[bus.mem_address] <= bus.mem_writedata;
    end
  end
  always @(negedge clk) if (bus.mem_read && bus.mem_write) overlap <= overlap + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    model_rdata = 8'h00;
  endtask

  // Presents one request at posedge+1, holds it while stalled, then drains any posted store.
  task automatic run_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                            input int b, output int stall_cyc, output int err_cnt,
                            output logic [7:0] rdata_fin, output int req_cyc);
    int guard;
    bit done;
    mem_b = b;
    bus.cpu_read = rd;
    bus.cpu_write = wr;
    bus.cpu_address = a;
    bus.cpu_writedata = d;
    stall_cyc = 0;
    err_cnt = 0;
    req_cyc = 0;
    rdata_fin = 8'h00;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.cpu_error) err_cnt++;
      if (bus.mem_read | bus.mem_write) req_cyc++;
      if (bus.cpu_stall) stall_cyc++;
      else begin
        done = 1'b1;
        rdata_fin = bus.cpu_readdata;
      end
      guard++;
      if (guard > 200 && !done) begin
        n_tests++;
        n_fail++;
        $display("FAIL stall_bound: stall still 1 after %0d cycles, required 0", guard);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    guard = 0;
    while ((bus.mem_read | bus.mem_write) && guard <= 200) begin
      @(negedge clk);
      if (bus.cpu_error) err_cnt++;
      req_cyc++;
      if (bus.cpu_stall) stall_cyc++;
      guard++;
      @(posedge clk);
      #1;
    end
    if (guard > 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_bound: request still 1 after %0d cycles, required 0", guard);
    end
  endtask

  function automatic int st_exp(input int n);
    return POSTED ? 0 : n;
  endfunction

  task automatic rand_txn();
    bit rd, wr, e;
    logic [7:0] a, d, x_rd, rf;
    int op, b, da, x_st, x_rq, st, ec, rq;
    op = int'($urandom_range(0, 9));
    rd = (op == 0) || (op >= 5);
    wr = (op <= 4);
    a = 8'(8'h40 + $urandom_range(0, 7));
    d = 8'($urandom);
    b = int'($urandom_range(0, 9));
    da = (b < 1) ? 1 : b;
    e = (da > TMO - 1);
    if (e) da = TMO - 1;
    if (rd && wr) begin
      x_st = 0;
      x_rq = 0;
      x_rd = model_rdata;
      e = 1'b1;
    end else begin
      x_rq = da + 1;
      x_st = (wr && POSTED) ? 0 : da + 1;
      x_rd = rd ? (e ? 8'h00 : model_mem[a]) : model_rdata;
    end
    run_access(rd, wr, a, d, b, st, ec, rf, rq);
    check("rnd_stall", st, x_st);
    check("rnd_err", ec, e);
    check("rnd_rdata", rf, x_rd);
    check("rnd_req", rq, x_rq);
    if (!(rd && wr)) begin
      if (rd) model_rdata = x_rd;
      else if (!e) model_mem[a] = d;
    end
  endtask

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    int         b;
    int         x_st;
    int         x_err;
    logic [7:0] x_rd;
    int         x_rq;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int st, ec, rq;
    logic [7:0] rf;

    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 5,   6,         0, 8'hA5, 6};
    vecs[1] = '{1'b0, 1'b1, 8'h20, 8'h3C, 5,   st_exp(6), 0, 8'hA5, 6};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 5,   6,         0, 8'h3C, 6};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 8'h99, 5,   0,         1, 8'h3C, 0};
    vecs[4] = '{1'b1, 1'b0, 8'h10, 8'h00, 100, 8,         1, 8'h00, 8};
    vecs[5] = '{1'b1, 1'b0, 8'h20, 8'h00, 0,   2,         0, 8'h3C, 2};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 1,   2,         0, 8'hA5, 2};
    vecs[7] = '{1'b1, 1'b0, 8'h20, 8'h00, 7,   8,         0, 8'h3C, 8};
    vecs[8] = '{1'b0, 1'b1, 8'h10, 8'h55, 8,   st_exp(8), 1, 8'h3C, 8};
    vecs[9] = '{1'b1, 1'b0, 8'h10, 8'h00, 2,   3,         0, 8'hA5, 3};

    // Reset with a request present: it must be ignored.
    reset = 1'b1;
    bus.cpu_read = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_address = 8'h10;
    bus.cpu_writedata = 8'h5A;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", bus.cpu_stall, 0);
    check("rst_err", bus.cpu_error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cpu_read = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_mem_writedata", bus.mem_writedata, 0);
    check("rst_readdata", bus.cpu_readdata, 0);
    check("rst_idle_stall", bus.cpu_stall, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].b, st, ec, rf, rq);
      check($sformatf("vec%0d_stall", i), st, vecs[i].x_st);
      check($sformatf("vec%0d_err", i), ec, vecs[i].x_err);
      check($sformatf("vec%0d_rdata", i), rf, vecs[i].x_rd);
      check($sformatf("vec%0d_req", i), rq, vecs[i].x_rq);
    end

`ifdef POSTED_WRITE_EN
    // Posted store followed at once by a load of the same address.
    mem_b = 3;
    bus.cpu_write = 1'b1;
    bus.cpu_address = 8'h30;
    bus.cpu_writedata = 8'h77;
    @(negedge clk);
    check("pw_accept_stall", bus.cpu_stall, 0);
    @(posedge clk);
    #1;
    bus.cpu_write = 1'b0;
    run_access(1'b1, 1'b0, 8'h30, 8'h00, 3, st, ec, rf, rq);
    check("pw_load_stall", st, 8);
    check("pw_load_err", ec, 0);
    check("pw_load_rdata", rf, 8'h77);
    check("pw_req", rq, 8);
`endif

    // Reset two cycles into WAIT: request drops, no error, rdata cleared.
    mem_b = 100;
    bus.cpu_read = 1'b1;
    bus.cpu_address = 8'h10;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_stall", bus.cpu_stall, 0);
    check("midrst_err", bus.cpu_error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cpu_read = 1'b0;
    model_reset();
    @(negedge clk);
    check("postrst_mem_read", bus.mem_read, 0);
    check("postrst_stall", bus.cpu_stall, 0);
    check("postrst_rdata", bus.cpu_readdata, 0);
    check("postrst_err", bus.cpu_error, 0);
    @(posedge clk);
    #1;

    for (int t = 0; t < 40; t++) begin
      rand_txn();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    check("mem_excl", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
